// File: rtl/encode_pack.sv
// encode_pack: packs variable-length LZS code fragments MSB-first into 64-bit little-endian FIFO words.
// Build macro ENCODE_PACK_STAT_EN adds the out_bytes compressed-length counter.
module encode_pack #(
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               tok_valid,
  input  logic [MAX_LEN-1:0] tok_code,
  input  logic [4:0]         tok_len,
  input  logic               tok_last,
  output logic               tok_ready,
  output logic [63:0]        fo_data,
  output logic [3:0]         fo_bcnt,
  output logic               fo_we,
  input  logic               fo_full,
`ifdef ENCODE_PACK_STAT_EN
  output logic [31:0]        out_bytes,
`endif
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_FLUSH, S_DONE} state_t;

  state_t      state_q;
  logic [79:0] acc_q, acc_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] fo_data_q;
  logic [3:0]  fo_bcnt_q;
  logic        fo_we_q, done_q;

  logic        full_word, emit_full, emit_tail, accept;
  logic [4:0]  len_eff;
  logic [79:0] base_acc, code_ext;
  logic [6:0]  base_cnt, shamt;
  logic [3:0]  tail_bcnt;
  logic [63:0] word;

  // The stream head lives at acc_q[79]; bits below the fill level are always zero,
  // so the tail word needs no explicit padding mask.
  always_comb begin
    full_word = (cnt_q >= 7'd64);
    emit_full = (state_q == S_PACK || state_q == S_FLUSH) && ce && !fo_full && full_word;
    emit_tail = (state_q == S_FLUSH) && ce && !fo_full && !full_word && (cnt_q != 7'd0);
    tok_ready = (state_q == S_PACK) && ce && (!full_word || !fo_full);
    accept    = tok_ready && tok_valid;
    len_eff   = (tok_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : tok_len;
    code_ext  = {{(80-MAX_LEN){1'b0}}, tok_code} & ((80'd1 << len_eff) - 80'd1);
    base_acc  = emit_full ? (acc_q << 64) : acc_q;
    base_cnt  = emit_full ? (cnt_q - 7'd64) : cnt_q;
    shamt     = 7'd80 - base_cnt - {2'b00, len_eff};
    tail_bcnt = 4'((cnt_q + 7'd7) >> 3);
    acc_d     = base_acc;
    cnt_d     = base_cnt;
    if (accept) begin
      acc_d = base_acc | (code_ext << shamt);
      cnt_d = base_cnt + {2'b00, len_eff};
    end
    if (emit_tail) begin
      acc_d = '0;
      cnt_d = '0;
    end
    // First stream byte goes to fo_data[7:0], each byte keeping its MSB-first bit order.
    word = '0;
    for (int j = 0; j < 8; j++) begin
      word[8*j +: 8] = acc_q[79-8*j -: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      fo_data_q <= '0;
      fo_bcnt_q <= '0;
      fo_we_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fo_we_q <= emit_full || emit_tail;
      if (emit_full || emit_tail) begin
        fo_data_q <= word;
        fo_bcnt_q <= emit_full ? 4'd8 : tail_bcnt;
      end
      case (state_q)
        S_IDLE:  if (ce) state_q <= S_PACK;
        S_PACK:  if (accept && tok_last) state_q <= S_FLUSH;
        S_FLUSH: begin
          if (ce && !full_word && (cnt_q == 7'd0 || emit_tail)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENCODE_PACK_STAT_EN
  logic [31:0] out_bytes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bytes_q <= '0;
    end else if (emit_full) begin
      out_bytes_q <= out_bytes_q + 32'd8;
    end else if (emit_tail) begin
      out_bytes_q <= out_bytes_q + {28'd0, tail_bcnt};
    end
  end

  assign out_bytes = out_bytes_q;
`endif

  assign fo_data = fo_data_q;
  assign fo_bcnt = fo_bcnt_q;
  assign fo_we   = fo_we_q;
  assign done    = done_q;

endmodule
